// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences one load/store at a time between the Memory stage
// and a single-port doubleword RAM with variable read latency. Sub-doubleword
// stores are done as read-modify-write; loads are lane-extracted and extended.
//
// Handshake: a request is taken on a cycle where req_valid && req_ready are both
// high; req_ready is high only while idle, and upstream holds the request until
// it is taken. resp_valid is a one-cycle completion pulse qualified by fault.
module mem_access_unit #(
  parameter int WORD    = 64,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [10:0]     opcode,
  input  logic [WORD-1:0] address,
  input  logic [WORD-1:0] write_data,
  output logic            stall,
  output logic            resp_valid,
  output logic [WORD-1:0] read_data,
  output logic            fault,
  output logic [WORD-1:0] ram_addr,
  output logic            ram_re,
  output logic            ram_we,
  output logic [WORD-1:0] ram_wdata,
  input  logic [WORD-1:0] ram_rdata,
  input  logic            ram_rvalid
);

  // Sized opcodes; every other opcode is treated as a doubleword access.
  localparam logic [10:0] OP_LDURB  = 11'h1C2;
  localparam logic [10:0] OP_STURB  = 11'h1C0;
  localparam logic [10:0] OP_LDURH  = 11'h3C2;
  localparam logic [10:0] OP_STURH  = 11'h3C0;
  localparam logic [10:0] OP_LDURSW = 11'h5C4;
  localparam logic [10:0] OP_STURW  = 11'h5C0;

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RMW_RD, S_WR, S_DONE, S_FAULT
  } state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  size_t           size_q, size_d, size_in;
  logic [2:0]      off_q, off_d;
  logic [WORD-1:0] wdata_q, wdata_d;
  logic [WORD-1:0] ram_addr_q, ram_addr_d;
  logic [WORD-1:0] ram_wdata_q, ram_wdata_d;
  logic [WORD-1:0] read_data_q, read_data_d;
  logic            ram_re_q, ram_re_d;
  logic            ram_we_q, ram_we_d;
  logic            resp_valid_q, resp_valid_d;
  logic            fault_q, fault_d;
  logic            req_ready_q, req_ready_d;
  logic            stall_q, stall_d;
  logic            misaligned;

  // Pull the addressed lane out of the doubleword and extend it to WORD bits.
  function automatic logic [WORD-1:0] extract_load(input logic [WORD-1:0] dword,
                                                   input size_t sz,
                                                   input logic [2:0] off);
    logic [WORD-1:0] sh;
    sh = dword >> {off, 3'b000};
    case (sz)
      SZ_B:    extract_load = {{(WORD-8){1'b0}}, sh[7:0]};
      SZ_H:    extract_load = {{(WORD-16){1'b0}}, sh[15:0]};
      SZ_W:    extract_load = {{(WORD-32){sh[31]}}, sh[31:0]};
      default: extract_load = dword;
    endcase
  endfunction

  // Replace the addressed lane of the doubleword with the low bytes of wdata.
  function automatic logic [WORD-1:0] merge_lane(input logic [WORD-1:0] dword,
                                                 input logic [WORD-1:0] wdata,
                                                 input size_t sz,
                                                 input logic [2:0] off);
    logic [WORD-1:0] mask;
    case (sz)
      SZ_B:    mask = WORD'(8'hFF);
      SZ_H:    mask = WORD'(16'hFFFF);
      SZ_W:    mask = WORD'(32'hFFFF_FFFF);
      default: mask = '1;
    endcase
    mask       = mask << {off, 3'b000};
    merge_lane = (dword & ~mask) | ((wdata << {off, 3'b000}) & mask);
  endfunction

  // Access size from the incoming opcode.
  always_comb begin
    case (opcode)
      OP_LDURB,  OP_STURB: size_in = SZ_B;
      OP_LDURH,  OP_STURH: size_in = SZ_H;
      OP_LDURSW, OP_STURW: size_in = SZ_W;
      default:             size_in = SZ_D;
    endcase
  end

  // Natural alignment check for the incoming request.
  always_comb begin
    case (size_in)
      SZ_H:    misaligned = address[0];
      SZ_W:    misaligned = |address[1:0];
      SZ_D:    misaligned = |address[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Next-state, datapath captures, and the registered outputs decoded from the next state.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    size_d      = size_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    read_data_d = '0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          size_d     = size_in;
          off_d      = address[2:0];
          wdata_d    = write_data;
          ram_addr_d = {address[WORD-1:3], 3'b000};
          timer_d    = '0;
          if (misaligned || (mem_read && mem_write)) begin
            state_d = S_FAULT;
          end else if (mem_read) begin
            state_d = S_RD;
          end else if (mem_write) begin
            if (size_in == SZ_D) begin
              state_d     = S_WR;
              ram_wdata_d = write_data;
            end else begin
              state_d = S_RMW_RD;
            end
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RD, S_RMW_RD: begin
        // Read data wins over the timer in the last allowed cycle.
        if (ram_rvalid) begin
          if (state_q == S_RD) begin
            state_d     = S_DONE;
            read_data_d = extract_load(ram_rdata, size_q, off_q);
          end else begin
            state_d     = S_WR;
            ram_wdata_d = merge_lane(ram_rdata, wdata_q, size_q, off_q);
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WR:    state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    ram_re_d     = (state_d == S_RD) || (state_d == S_RMW_RD);
    ram_we_d     = (state_d == S_WR);
    resp_valid_d = (state_d == S_DONE) || (state_d == S_FAULT);
    fault_d      = (state_d == S_FAULT);
    req_ready_d  = (state_d == S_IDLE);
    stall_d      = ~req_ready_d;
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      size_q       <= SZ_D;
      off_q        <= '0;
      wdata_q      <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      read_data_q  <= '0;
      ram_re_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      req_ready_q  <= 1'b1;
      stall_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      size_q       <= size_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      read_data_q  <= read_data_d;
      ram_re_q     <= ram_re_d;
      ram_we_q     <= ram_we_d;
      resp_valid_q <= resp_valid_d;
      fault_q      <= fault_d;
      req_ready_q  <= req_ready_d;
      stall_q      <= stall_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign stall      = stall_q;
  assign resp_valid = resp_valid_q;
  assign read_data  = read_data_q;
  assign fault      = fault_q;
  assign ram_addr   = ram_addr_q;
  assign ram_re     = ram_re_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized operations
// compared against a byte-level reference model of the memory access rules.
module tb_mem_access_unit;

  localparam logic [10:0] LDUR   = 11'h7C2;
  localparam logic [10:0] STUR   = 11'h7C0;
  localparam logic [10:0] LDURB  = 11'h1C2;
  localparam logic [10:0] STURB  = 11'h1C0;
  localparam logic [10:0] LDURH  = 11'h3C2;
  localparam logic [10:0] STURH  = 11'h3C0;
  localparam logic [10:0] LDURSW = 11'h5C4;
  localparam logic [10:0] STURW  = 11'h5C0;
  localparam int TIMEOUT = 16;

  logic        clk, reset;
  logic        req_valid, req_ready, mem_read, mem_write;
  logic [10:0] opcode;
  logic [63:0] address, write_data;
  logic        stall, resp_valid, fault;
  logic [63:0] read_data, ram_addr, ram_wdata, ram_rdata;
  logic        ram_re, ram_we, ram_rvalid;

  int n_checks = 0;
  int n_fail   = 0;

  // Simulated RAM contents, keyed by doubleword address.
  logic [63:0] mem [logic [63:0]];

  logic [10:0] ops [8] = '{LDUR, STUR, LDURB, STURB, LDURH, STURH, LDURSW, STURW};

  typedef struct {
    int          ready_wait;
    int          resp_cyc;
    logic        fault;
    logic [63:0] rdata;
    int          we_cnt;
    int          we_cyc;
    logic [63:0] wdata;
    int          re_cnt;
    int          re_first;
    logic [63:0] addr_seen;
    int          stall_bad;
  } obs_t;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  mem_access_unit #(.WORD(64), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .opcode(opcode),
    .address(address), .write_data(write_data), .stall(stall),
    .resp_valid(resp_valid), .read_data(read_data), .fault(fault),
    .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_rvalid(ram_rvalid)
  );

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return 64'd0;
  endfunction

  // Reference model: outcome of one request given RAM contents and read delay
  // (delay = cycles after the first ram_re cycle before rvalid; <0 = never).
  function automatic void model(input logic rd, input logic wr, input logic [10:0] opc,
                                input logic [63:0] addr, input logic [63:0] data,
                                input int delay, output logic e_fault,
                                output logic [63:0] e_rdata, output logic [63:0] e_word,
                                output int e_resp, output int e_we, output int e_we_cyc,
                                output int e_re);
    int nb;
    int off;
    logic [63:0] cur, v;
    nb  = (opc == LDURB  || opc == STURB) ? 1 :
          (opc == LDURH  || opc == STURH) ? 2 :
          (opc == LDURSW || opc == STURW) ? 4 : 8;
    off = int'(addr[2:0]);
    cur = mem_rd(addr & ~64'h7);
    e_fault = 1'b0; e_rdata = 64'd0; e_word = cur;
    e_resp = 1; e_we = 0; e_we_cyc = -1; e_re = 0;
    if ((addr % nb) != 0 || (rd && wr)) begin
      e_fault = 1'b1;
      return;
    end
    if (!rd && !wr) return;
    if (rd || nb < 8) begin
      if (delay < 0 || delay >= TIMEOUT) begin
        e_fault = 1'b1; e_re = TIMEOUT; e_resp = TIMEOUT + 1;
        return;
      end
      e_re = delay + 1;
    end
    if (rd) begin
      v = cur >> (8 * off);
      if (nb < 8) v = v & ((64'd1 << (8 * nb)) - 64'd1);
      if (opc == LDURSW && v[31]) v = v | 64'hFFFF_FFFF_0000_0000;
      e_rdata = v;
      e_resp  = delay + 2;
    end else begin
      for (int i = 0; i < nb; i++) e_word[8*(off+i) +: 8] = data[8*i +: 8];
      e_we     = 1;
      e_we_cyc = (nb == 8) ? 1 : delay + 2;
      e_resp   = (nb == 8) ? 2 : delay + 3;
    end
  endfunction

  // Driver: issue one request, play the RAM, record what the DUT does up to resp_valid.
  task automatic run_op(input logic rd, input logic wr, input logic [10:0] opc,
                        input logic [63:0] addr, input logic [63:0] data,
                        input int delay, output obs_t o);
    o = '{default: 0};
    o.resp_cyc = -1; o.we_cyc = -1; o.re_first = -1;
    @(posedge clk); #1;
    while (req_ready !== 1'b1 && o.ready_wait < 50) begin
      o.ready_wait++;
      @(posedge clk); #1;
    end
    req_valid = 1'b1; mem_read = rd; mem_write = wr;
    opcode = opc; address = addr; write_data = data;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      ram_rvalid = 1'b0;
      ram_rdata  = {$urandom, $urandom};
      if (cyc == 1) o.addr_seen = ram_addr;
      if (ram_re === 1'b1) begin
        o.re_cnt++;
        if (o.re_first < 0) o.re_first = cyc;
      end
      if (ram_we === 1'b1) begin
        o.we_cnt++; o.we_cyc = cyc; o.wdata = ram_wdata;
      end
      if (stall !== 1'b1 || req_ready !== 1'b0) o.stall_bad++;
      if (resp_valid === 1'b1) begin
        o.resp_cyc = cyc; o.fault = fault; o.rdata = read_data;
        break;
      end
      if (ram_re === 1'b1 && delay >= 0 && (cyc - o.re_first) == delay) begin
        ram_rvalid = 1'b1;
        ram_rdata  = mem_rd(ram_addr);
      end
      @(posedge clk); #1;
    end
    ram_rvalid = 1'b0;
  endtask

  // Run one request through the model and the DUT and compare every observable.
  task automatic test_op(input string name, input logic rd, input logic wr,
                         input logic [10:0] opc, input logic [63:0] addr,
                         input logic [63:0] data, input int delay);
    obs_t o;
    logic e_fault;
    logic [63:0] e_rdata, e_word;
    int e_resp, e_we, e_we_cyc, e_re;
    model(rd, wr, opc, addr, data, delay, e_fault, e_rdata, e_word, e_resp, e_we, e_we_cyc, e_re);
    run_op(rd, wr, opc, addr, data, delay, o);
    n_checks++; if (o.ready_wait !== 0) begin n_fail++; $display("FAIL %s accept_wait: got %0d want 0", name, o.ready_wait); end
    n_checks++; if (o.resp_cyc !== e_resp) begin n_fail++; $display("FAIL %s resp_cycle: got %0d want %0d", name, o.resp_cyc, e_resp); end
    n_checks++; if (o.fault !== e_fault) begin n_fail++; $display("FAIL %s fault: got %0b want %0b", name, o.fault, e_fault); end
    n_checks++; if (o.rdata !== e_rdata) begin n_fail++; $display("FAIL %s read_data: got %h want %h", name, o.rdata, e_rdata); end
    n_checks++; if (o.re_cnt !== e_re) begin n_fail++; $display("FAIL %s ram_re_cycles: got %0d want %0d", name, o.re_cnt, e_re); end
    n_checks++; if (o.we_cnt !== e_we) begin n_fail++; $display("FAIL %s ram_we_count: got %0d want %0d", name, o.we_cnt, e_we); end
    n_checks++; if (o.we_cyc !== e_we_cyc) begin n_fail++; $display("FAIL %s ram_we_cycle: got %0d want %0d", name, o.we_cyc, e_we_cyc); end
    n_checks++; if (o.stall_bad !== 0) begin n_fail++; $display("FAIL %s stall_busy: got %0d bad cycles want 0", name, o.stall_bad); end
    n_checks++; if (o.addr_seen !== (addr & ~64'h7)) begin n_fail++; $display("FAIL %s ram_addr: got %h want %h", name, o.addr_seen, addr & ~64'h7); end
    if (e_we == 1) begin
      n_checks++; if (o.wdata !== e_word) begin n_fail++; $display("FAIL %s ram_wdata: got %h want %h", name, o.wdata, e_word); end
      mem[addr & ~64'h7] = e_word;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    opcode = 11'd0; address = 64'd0; write_data = 64'd0;
    ram_rdata = 64'd0; ram_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset stall: got %b want 0", stall); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset resp_valid: got %b want 0", resp_valid); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset fault: got %b want 0", fault); end
    n_checks++; if (ram_re !== 1'b0) begin n_fail++; $display("FAIL reset ram_re: got %b want 0", ram_re); end
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset ram_we: got %b want 0", ram_we); end
    n_checks++; if (read_data !== 64'd0) begin n_fail++; $display("FAIL reset read_data: got %h want 0", read_data); end
    n_checks++; if (ram_addr !== 64'd0) begin n_fail++; $display("FAIL reset ram_addr: got %h want 0", ram_addr); end
    n_checks++; if (ram_wdata !== 64'd0) begin n_fail++; $display("FAIL reset ram_wdata: got %h want 0", ram_wdata); end
    reset = 1'b0;
  endtask

  // Byte store at offset 3: lane bits 31:24 take 0xAB, the rest of the word is kept.
  task automatic test_sturb_rmw();
    mem[64'h10] = 64'h1122334455667788;
    test_op("sturb_rmw", 1'b0, 1'b1, STURB, 64'h13, 64'hAB, 3);
    n_checks++; if (mem[64'h10] !== 64'h11223344AB667788) begin n_fail++; $display("FAIL sturb_rmw model_word: got %h want %h", mem[64'h10], 64'h11223344AB667788); end
  endtask

  task automatic test_ldursw();
    mem[64'h20] = 64'h80000000_12345678;
    test_op("ldursw_sign", 1'b1, 1'b0, LDURSW, 64'h24, 64'd0, 2);
  endtask

  task automatic test_faults();
    test_op("ldurh_misaligned", 1'b1, 1'b0, LDURH, 64'h21, 64'd0, 0);
    test_op("read_and_write", 1'b1, 1'b1, LDUR, 64'h8, 64'd5, 0);
    test_op("no_flags", 1'b0, 1'b0, LDUR, 64'h8, 64'd0, 0);
  endtask

  task automatic test_timeout();
    test_op("ldur_timeout", 1'b1, 1'b0, LDUR, 64'h30, 64'd0, -1);
    test_op("ldur_last_cycle", 1'b1, 1'b0, LDUR, 64'h30, 64'd0, TIMEOUT - 1);
  endtask

  task automatic test_back_to_back();
    test_op("b2b_stur", 1'b0, 1'b1, STUR, 64'h8, 64'hDEADBEEF, 0);
    test_op("b2b_ldur", 1'b1, 1'b0, LDUR, 64'h8, 64'd0, 1);
    n_checks++; if (mem_rd(64'h8) !== 64'h00000000DEADBEEF) begin n_fail++; $display("FAIL b2b model_word: got %h want %h", mem_rd(64'h8), 64'h00000000DEADBEEF); end
  endtask

  task automatic test_reset_mid_rmw();
    int resp_seen;
    int we_seen;
    mem[64'h40] = 64'h0123456789ABCDEF;
    @(posedge clk); #1;
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1;
    opcode = STURB; address = 64'h41; write_data = 64'h5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (ram_re !== 1'b1) begin n_fail++; $display("FAIL mid_rmw ram_re_before: got %b want 1", ram_re); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++; if (ram_re !== 1'b0) begin n_fail++; $display("FAIL mid_rmw ram_re_after: got %b want 0", ram_re); end
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL mid_rmw ram_we_after: got %b want 0", ram_we); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rmw req_ready_after: got %b want 1", req_ready); end
    resp_seen = 0; we_seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (resp_valid === 1'b1) resp_seen++;
      if (ram_we === 1'b1) we_seen++;
      // A stray read strobe while idle must be ignored.
      ram_rvalid = (c == 2);
      ram_rdata  = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    ram_rvalid = 1'b0;
    n_checks++; if (resp_seen !== 0) begin n_fail++; $display("FAIL mid_rmw resp_after_reset: got %0d want 0", resp_seen); end
    n_checks++; if (we_seen !== 0) begin n_fail++; $display("FAIL mid_rmw we_after_reset: got %0d want 0", we_seen); end
    n_checks++; if (mem_rd(64'h40) !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL mid_rmw model_word: got %h want %h", mem_rd(64'h40), 64'h0123456789ABCDEF); end
  endtask

  task automatic test_random();
    logic [10:0] opc;
    logic [63:0] addr, data;
    logic rd, wr;
    int idx, kind, delay, nb;
    string name;
    for (int a = 0; a < 64; a += 8) mem[64'(a)] = {$urandom, $urandom};
    for (int i = 0; i < 60; i++) begin
      idx = $urandom_range(0, 8);
      if (idx == 8) begin
        opc = 11'($urandom_range(0, 2047));
        rd  = 1'($urandom_range(0, 1));
        wr  = ~rd;
      end else begin
        opc = ops[idx];
        rd  = (idx % 2 == 0);
        wr  = ~rd;
      end
      kind = $urandom_range(0, 19);
      if (kind == 0) begin rd = 1'b1; wr = 1'b1; end
      if (kind == 1) begin rd = 1'b0; wr = 1'b0; end
      nb   = (idx == 2 || idx == 3) ? 1 : (idx == 4 || idx == 5) ? 2 : (idx == 6 || idx == 7) ? 4 : 8;
      addr = 64'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) addr = addr & ~64'(nb - 1);
      data  = {$urandom, $urandom};
      delay = ($urandom_range(0, 15) == 0) ? TIMEOUT + 2 : $urandom_range(0, 5);
      name  = $sformatf("rand%0d", i);
      test_op(name, rd, wr, opc, addr, data, delay);
    end
  endtask

  initial begin
    test_reset();
    test_sturb_rmw();
    test_ldursw();
    test_faults();
    test_timeout();
    test_back_to_back();
    test_reset_mid_rmw();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
